// File: rtl/r_unloader.sv
// rtl/r_unloader.sv - BRAM R result-row readback engine with credit-limited stream FIFO
// Optional R_UNLOADER_CHECKSUM_EN adds an XOR checksum of every emitted lane.
module r_unloader #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH:0]                  row_count,
  output logic [ADDR_WIDTH-1:0]                bram_r_r_addr,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  bram_r_r_data,
  output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic                                 busy,
  output logic                                 done
`ifdef R_UNLOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]                checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]                          state;
  logic [ADDR_WIDTH:0]                 issue_left;
  logic [ADDR_WIDTH:0]                 beats_left;
  logic                                rd_vld;
  logic [RD_LATENCY-1:0]               tag;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]                       wr_ptr;
  logic [PW-1:0]                       rd_ptr;
  logic [OW-1:0]                       fifo_count;
  logic                                push;
  logic                                pop;
  logic [CW-1:0]                       pending;
  logic                                credit;

  // Credit counts every read not yet popped: the one on the bus, those in the delay line, and the FIFO.
  always_comb begin
    push     = tag[RD_LATENCY-1];
    m_tvalid = (fifo_count != '0);
    m_tdata  = m_tvalid ? fifo_mem[rd_ptr] : '0;
    m_tlast  = m_tvalid && (beats_left == (ADDR_WIDTH+1)'(1));
    pop      = m_tvalid && m_tready;
    busy     = (state == S_ISSUE) || (state == S_DRAIN);
    done     = (state == S_DONE);
    pending  = CW'(fifo_count) + CW'(rd_vld);
    for (int i = 0; i < RD_LATENCY; i++) pending = pending + CW'(tag[i]);
    pending  = pending - CW'(pop);
    credit   = (pending < CW'(FIFO_DEPTH));
  end

`ifdef R_UNLOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] beat_xor;
  always_comb begin
    beat_xor = '0;
    for (int i = 0; i < PE_COUNT; i++) beat_xor = beat_xor ^ m_tdata[i];
  end

  always_ff @(posedge clk) begin
    if (rst)                            checksum <= '0;
    else if (state == S_IDLE && start)  checksum <= '0;
    else if (pop)                       checksum <= checksum ^ beat_xor;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bram_r_r_addr <= '0;
      rd_vld        <= 1'b0;
      tag           <= '0;
      issue_left    <= '0;
      beats_left    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      rd_vld <= 1'b0;
      tag[0] <= rd_vld;
      for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];

      if (push) begin
        fifo_mem[wr_ptr] <= bram_r_r_data;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr     <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
        beats_left <= beats_left - (ADDR_WIDTH+1)'(1);
      end
      fifo_count <= fifo_count + OW'(push) - OW'(pop);

      case (state)
        S_IDLE: begin
          if (start) begin
            beats_left <= row_count;
            if (row_count == '0) begin
              state <= S_DONE;
            end else begin
              bram_r_r_addr <= base_addr;
              rd_vld        <= 1'b1;
              issue_left    <= row_count - (ADDR_WIDTH+1)'(1);
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue_left == '0) begin
            state <= S_DRAIN;
          end else if (credit) begin
            bram_r_r_addr <= bram_r_r_addr + ADDR_WIDTH'(1);
            rd_vld        <= 1'b1;
            issue_left    <= issue_left - (ADDR_WIDTH+1)'(1);
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_unloader.sv
// tb/tb_r_unloader.sv - scoreboard bench for r_unloader
// Builds with or without R_UNLOADER_CHECKSUM_EN.
module tb_r_unloader;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [10:0]       base_addr = '0;
  logic [11:0]       row_count = '0;
  logic [10:0]       bram_r_r_addr;
  logic [3:0][31:0]  bram_r_r_data;
  logic [3:0][31:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              m_tlast;
  logic              busy;
  logic              done;
`ifdef R_UNLOADER_CHECKSUM_EN
  logic [31:0]       checksum;
  logic [31:0]       exp_csum;
`endif

  r_unloader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .bram_r_r_addr(bram_r_r_addr), .bram_r_r_data(bram_r_r_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done)
`ifdef R_UNLOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [127:0] mem [2048];
  logic [127:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mem[bram_r_r_addr];
    d2 <= d1;
  end
  assign bram_r_r_data = d2;

  typedef struct packed { logic [127:0] d; logic l; } beat_t;
  beat_t sb [$];

  int total = 0, bad = 0;
  int ecount = 0, t0 = 0;
  int done_cyc, first_vcyc, nbeats;
  bit busy_seen, mon_en = 0, rmode = 0;
  bit prev_stall = 0, prev_done = 0;
  logic [127:0] prev_d;
  logic prev_l;
  int alog [1:8];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) ecount++;

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      automatic int cyc = ecount - t0 + 1;
      automatic beat_t e;
      if (busy) busy_seen = 1;
      if (done && prev_done) chk("done_pulse", 1, 0);
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
`ifdef R_UNLOADER_CHECKSUM_EN
        chk("checksum", checksum, exp_csum);
`endif
      end
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && first_vcyc < 0) first_vcyc = cyc;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_data", m_tdata, e.d);
          chk("beat_last", m_tlast, e.l);
        end
        nbeats++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      prev_done = done;
    end
  end

  task automatic launch(input int base, input int cnt);
    beat_t b;
`ifdef R_UNLOADER_CHECKSUM_EN
    exp_csum = '0;
`endif
    for (int i = 0; i < cnt; i++) begin
      b.d = mem[(base + i) % 2048];
      b.l = (i == cnt - 1);
      sb.push_back(b);
`ifdef R_UNLOADER_CHECKSUM_EN
      for (int k = 0; k < 4; k++) exp_csum = exp_csum ^ b.d[k*32 +: 32];
`endif
    end
    done_cyc = -1; first_vcyc = -1; busy_seen = 0; nbeats = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 11'(base); row_count = 12'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = ecount;
  endtask

  task automatic run(input int base, input int cnt, input bit dup);
    launch(base, cnt);
    for (int k = 0; k < 3000 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k < 8) alog[k+1] = bram_r_r_addr;
      if (dup && k == 2) begin
        start = 1'b1; base_addr = 11'd0; row_count = 12'd7;
      end else start = 1'b0;
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    for (int r = 0; r < 2048; r++)
      mem[r] = {32'(4*r+3), 32'(4*r+2), 32'(4*r+1), 32'(4*r)};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_addr", bram_r_r_addr, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    mon_en = 1;

    run(0, 50, 0);
    chk("s1_first_valid", first_vcyc, 4);
    chk("s1_done_cyc", done_cyc, 54);
    chk("s1_beats", nbeats, 50);

    rmode = 1;
    run(0, 50, 0);
    chk("s2_beats", nbeats, 50);
    rmode = 0;

    run(2046, 4, 0);
    chk("wrap_a1", alog[1], 2046);
    chk("wrap_a2", alog[2], 2047);
    chk("wrap_a3", alog[3], 0);
    chk("wrap_a4", alog[4], 1);
    chk("wrap_beats", nbeats, 4);

    run(0, 0, 0);
    chk("z_done_cyc", done_cyc, 1);
    chk("z_beats", nbeats, 0);
    chk("z_busy", busy_seen, 0);
    chk("z_valid", first_vcyc < 0, 1);

    launch(0, 50);
    for (int k = 0; k < 500 && nbeats < 10; k++) @(negedge clk);
    chk("r_ten_beats", nbeats >= 10, 1);
    @(posedge clk);
    #1;
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("r_addr", bram_r_r_addr, 0);
    chk("r_valid", m_tvalid, 0);
    chk("r_data", m_tdata, 0);
    chk("r_last", m_tlast, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_no_done", done_cyc, -1);
    sb.delete();
    prev_stall = 0;
    prev_done = 0;
    mon_en = 1;
    run(20, 5, 1);
    chk("r_fresh_beats", nbeats, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_unloader.md
# r_unloader

Result-readback engine on the PS side of the datapath: it drains computed rows from BRAM R and is the reader for the datapath's result port. After a `start` pulse, normally driven from `out_data_valid`, it issues sequential row addresses on the BRAM R read port and absorbs the fixed read latency. Returned rows are delivered as a flow-controlled stream (valid/ready/last) toward the PS/DMA. A small credit-limited FIFO makes backpressure lossless.

## Interface
Parameters:
- `PE_COUNT`, 4, lanes per row
- `DATA_WIDTH`, 32, bits per lane
- `ADDR_WIDTH`, 11, BRAM R address width
- `RD_LATENCY`, 2, cycles from address to valid `bram_r_r_data`
- `FIFO_DEPTH`, `RD_LATENCY`+2, output buffer entries

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a transfer
- `base_addr`  in  `ADDR_WIDTH`  first row, sampled on `start`
- `row_count`  in  `ADDR_WIDTH`+1  number of rows, sampled on `start`
- `bram_r_r_addr`  out  `ADDR_WIDTH`  BRAM R read address (registered)
- `bram_r_r_data`  in  [`PE_COUNT`-1:0][`DATA_WIDTH`-1:0]  BRAM R read data
- `m_tdata`  out  [`PE_COUNT`-1:0][`DATA_WIDTH`-1:0]  row beat
- `m_tvalid`  out  1  beat valid
- `m_tready`  in  1  sink ready
- `m_tlast`  out  1  marks the final row
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states and transitions:
  - IDLE: on `start` → ISSUE (or DONE if `row_count`=0).
  - ISSUE: issues one read per cycle while credit is available. After the last address → DRAIN.
  - DRAIN: waits for the last-beat handshake → DONE.
  - DONE: pulses `done` for one cycle → IDLE.
- Credit rule: a read is issued only if (reads in flight + FIFO occupancy − pop this cycle) < `FIFO_DEPTH`.
  - The FIFO never overflows.
  - Returned data is never dropped.
- Address sequence is `base_addr`+i, i=0..`row_count`-1, modulo 2^`ADDR_WIDTH`. Wrap is silent.
- A returning row is tagged by a delay line of width `RD_LATENCY`. It is captured into the FIFO on the clock edge where it is valid.
- Beats are emitted in issue order. `m_tlast`=1 only on beat `row_count`-1.
- While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` hold stable.
- `start` while `busy`=1 is ignored.
- `busy`=1 from the cycle after an accepted `start` through DRAIN. `busy`=0 in DONE.
- Reset values: `bram_r_r_addr`=0, `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `busy`=0, `done`=0, FIFO empty, FSM IDLE.
- `rst` mid-transfer: abandons the transfer; in-flight reads are discarded, never emitted. No `done` pulse.

## Timing
- `start` sampled at edge 0 → `bram_r_r_addr`=`base_addr` in cycle 1.
- Row data valid in cycle 1+`RD_LATENCY` → `m_tvalid`=1 in cycle 2+`RD_LATENCY` (cycle 4 at defaults).
- With `m_tready` held high: one beat per cycle, no bubbles.
- `done` asserts in the cycle after the `m_tlast` handshake.
- `row_count`=0: `done` in cycle 1, no beats, no reads.
- FIFO push and pop in the same cycle are both honoured. Full-throughput pass-through occupancy stays constant.

## Configuration
- `R_UNLOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [`DATA_WIDTH`-1:0], the XOR of every lane of every emitted beat.
  - It is cleared on accepted `start` and on `rst`, and valid while `done`=1.
- Undefined: no port, no logic.

## Test plan
- Rows 0..49 preloaded with lane = 4·row+lane, `base_addr`=0, `row_count`=50, `m_tready`=1 → 50 beats in order, first `m_tvalid` cycle 4, `m_tlast` on beat 49 only, `done` in cycle 54.
- Same load, `m_tready` random 50% → identical 50-beat sequence, no drops or duplicates, `m_tdata` stable while stalled, in-flight+FIFO never > 4.
- `base_addr`=2046, `row_count`=4 → addresses 2046, 2047, 0, 1; beats match those rows.
- `row_count`=0 → no `m_tvalid`, `done` in cycle 1, `busy` never set.
- `rst` after 10 beats of a 50-row transfer → all outputs 0 next cycle. A fresh `start` (base 20, count 5) emits exactly rows 20..24, no stale beats. A second `start` pulse during it is ignored.
- With `R_UNLOADER_CHECKSUM_EN`: rows of scenario 1 → `checksum` equals the bench-computed XOR at `done`.
